// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem address and
// loads the IF/ID pipeline register under stall/flush/redirect control.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             pc_src,
    input  logic [31:0]      pc_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic [31:0]      if_id_ins,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] ins;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{pc: 32'h0, pc_plus4: 32'h4, ins: NOP_INS, valid: 1'b0};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_id_load;
    if_id_t      if_id;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign if_id_load = !flush_d && !stall_d;

    // Redirect wins over stall_f; the target is forced word-aligned.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (pc_src)
            pc <= {pc_target[31:2], 2'b00};
        else if (!stall_f)
            pc <= pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_d)
            if_id <= BUBBLE;
        else if (!stall_d)
            if_id <= '{pc: pc, pc_plus4: pc_plus4, ins: imem_rdata, valid: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            misalign_err <= pc_src && (pc_target[1:0] != 2'b00);
            if (if_id_load)
                fetch_count <= fetch_count + 1'b1;
        end
    end

    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_ins      = if_id.ins;
    assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural model pushes the expected state per
// driven cycle, which is popped and compared one edge later.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pc_src;
    logic [31:0] pc_target;
    logic [31:0] imem_addr, imem_rdata, imem_addr4, imem_rdata4;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_ins;
    logic        if_id_valid, misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] if_id_pc4, if_id_pc_plus44, if_id_ins4;
    logic        if_id_valid4, misalign_err4;
    logic [3:0]  fetch_count4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata  = imem_word(imem_addr);
    assign imem_rdata4 = imem_word(imem_addr4);

    if_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src(pc_src), .pc_target(pc_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_ins(if_id_ins),
        .if_id_valid(if_id_valid), .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    if_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src(pc_src), .pc_target(pc_target), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
        .if_id_pc(if_id_pc4), .if_id_pc_plus4(if_id_pc_plus44), .if_id_ins(if_id_ins4),
        .if_id_valid(if_id_valid4), .misalign_err(misalign_err4), .fetch_count(fetch_count4)
    );

    typedef struct {
        logic [31:0] pc, ipc, ipc4, ins, cnt;
        logic        vld, mis;
    } exp_t;

    exp_t m;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                        input logic ps, input logic [31:0] tgt);
        exp_t n, e;
        @(negedge clk);
        rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src = ps; pc_target = tgt;
        n = m;
        if (r) begin
            n.pc = 32'h0; n.ipc = 32'h0; n.ipc4 = 32'h4; n.ins = 32'h13;
            n.vld = 1'b0; n.mis = 1'b0; n.cnt = 32'h0;
        end else begin
            if (ps)       n.pc = tgt & 32'hFFFF_FFFC;
            else if (!sf) n.pc = m.pc + 32'd4;
            if (fl) begin
                n.ipc = 32'h0; n.ipc4 = 32'h4; n.ins = 32'h13; n.vld = 1'b0;
            end else if (!sd) begin
                n.ipc = m.pc; n.ipc4 = m.pc + 32'd4; n.ins = imem_word(m.pc); n.vld = 1'b1;
                n.cnt = m.cnt + 32'd1;
            end
            n.mis = ps && (tgt[1:0] != 2'b00);
        end
        sb.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc",     {32'h0, imem_addr},      {32'h0, e.pc});
        check("ifid_pc",{32'h0, if_id_pc},       {32'h0, e.ipc});
        check("ifid_p4",{32'h0, if_id_pc_plus4}, {32'h0, e.ipc4});
        check("ifid_ins",{32'h0, if_id_ins},     {32'h0, e.ins});
        check("valid",  {63'h0, if_id_valid},    {63'h0, e.vld});
        check("mis",    {63'h0, misalign_err},   {63'h0, e.mis});
        check("cnt",    {32'h0, fetch_count},    {32'h0, e.cnt});
        check("cnt4",   {60'h0, fetch_count4},   {60'h0, e.cnt[3:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src = 1'b0;
        pc_target = 32'h0;

        // Reset overrides a concurrent redirect and stall.
        step(1, 1, 0, 0, 1, 32'h500);
        step(1, 0, 0, 0, 1, 32'h500);
        check("rst_pc",  {32'h0, imem_addr},   64'h0);
        check("rst_ins", {32'h0, if_id_ins},   64'h13);
        check("rst_vld", {63'h0, if_id_valid}, 64'h0);

        // Free run from RESET_PC.
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("run_pc",  {32'h0, if_id_pc},    64'h8);
        check("run_ins", {32'h0, if_id_ins},   64'h1000_0002);
        check("run_cnt", {32'h0, fetch_count}, 64'h3);

        // Load-use stall at pc=0x10.
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 1, 0, 0, 0);
        check("stl_addr", {32'h0, imem_addr},   64'h10);
        check("stl_ifid", {32'h0, if_id_pc},    64'hC);
        check("stl_cnt",  {32'h0, fetch_count}, 64'h4);
        step(0, 0, 0, 0, 0, 0);
        check("rel_pc",   {32'h0, imem_addr},   64'h14);
        check("rel_ifid", {32'h0, if_id_pc},    64'h10);

        // Taken branch at pc=0x20.
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("br_from", {32'h0, imem_addr}, 64'h20);
        step(0, 0, 0, 1, 1, 32'h100);
        check("br_pc",  {32'h0, imem_addr},   64'h100);
        check("br_ins", {32'h0, if_id_ins},   64'h13);
        check("br_vld", {63'h0, if_id_valid}, 64'h0);
        step(0, 0, 0, 0, 0, 0);
        check("br_ifid", {32'h0, if_id_pc},    64'h100);
        check("br_vld2", {63'h0, if_id_valid}, 64'h1);

        // Flush beats stall_d.
        step(0, 0, 1, 1, 0, 0);
        check("fs_vld", {63'h0, if_id_valid}, 64'h0);
        check("fs_ins", {32'h0, if_id_ins},   64'h13);

        // Misaligned jalr target.
        step(0, 0, 0, 1, 1, 32'h206);
        check("mj_pc",  {32'h0, imem_addr},    64'h204);
        check("mj_mis", {63'h0, misalign_err}, 64'h1);
        step(0, 0, 0, 0, 0, 0);
        check("mj_mis0", {63'h0, misalign_err}, 64'h0);

        // stall_f without stall_d reloads the same pc.
        repeat (2) step(0, 1, 0, 0, 0, 0);
        check("sf_ifid", {32'h0, if_id_pc}, 64'h208);

        // PC wrap at the top of the address space.
        step(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        check("wr_pc",   {32'h0, imem_addr},      64'h0);
        check("wr_ifid", {32'h0, if_id_pc},       64'hFFFF_FFFC);
        check("wr_p4",   {32'h0, if_id_pc_plus4}, 64'h0);

        // Random traffic.
        for (int i = 0; i < 60; i++)
            step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom);

        // Reset mid-stall/redirect, then wrap the 4-bit counter.
        step(1, 1, 1, 0, 1, 32'h777);
        step(0, 0, 0, 0, 0, 0);
        check("pr_ifid", {32'h0, if_id_pc}, 64'h0);
        repeat (16) step(0, 0, 0, 0, 0, 0);
        check("c4_wrap", {60'h0, fetch_count4}, 64'h1);
        check("c32",     {32'h0, fetch_count},  64'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register and drives the instruction memory read address. The instruction memory is combinational, word-indexed by PC[31:2].
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall and flush from the hazard unit, and branch/jump redirects resolved in EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INS, 32'h0000_0013, encoding inserted into IF/ID on flush or reset (addi x0,x0,0).
- CNT_W, 32, width of the retired-fetch performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_f  input  1  hold PC (load-use hazard).
- stall_d  input  1  hold IF/ID register.
- flush_d  input  1  replace IF/ID contents with bubble.
- pc_src  input  1  redirect request from EX (taken branch / jal / jalr).
- pc_target  input  32  redirect target address.
- imem_addr  output  32  read address to instruction memory; equals current PC.
- imem_rdata  input  32  instruction returned combinationally for imem_addr.
- if_id_pc  output  32  PC of instruction held in IF/ID.
- if_id_pc_plus4  output  32  if_id_pc + 4.
- if_id_ins  output  32  instruction held in IF/ID.
- if_id_valid  output  1  1 = IF/ID holds a real fetched instruction, 0 = bubble.
- misalign_err  output  1  one-cycle pulse: last redirect target had target[1:0] != 0.
- fetch_count  output  CNT_W  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC.
  - if_id_ins <= NOP_INS; if_id_pc <= 0; if_id_pc_plus4 <= 4; if_id_valid <= 0.
  - misalign_err <= 0; fetch_count <= 0.
  - Reset overrides every other input.
- imem_addr = pc, purely combinational. No extra latency: the instruction at pc is captured at the next edge.
- PC update (per edge, priority high to low):
  1. pc_src=1: pc <= {pc_target[31:2],2'b00}. Redirect beats stall_f.
  2. stall_f=1: pc holds.
  3. Otherwise: pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- IF/ID update (per edge, priority high to low):
  1. flush_d=1: if_id_ins <= NOP_INS; if_id_valid <= 0; if_id_pc <= 0; if_id_pc_plus4 <= 4. Flush beats stall_d.
  2. stall_d=1: all IF/ID fields hold.
  3. Otherwise: if_id_ins <= imem_rdata; if_id_pc <= pc; if_id_pc_plus4 <= pc + 4; if_id_valid <= 1.
- Wrong-path handling: flush_d is not derived internally. The hazard unit asserts flush_d=1 together with pc_src=1, so the wrong-path instruction fetched in the redirect cycle is dropped.
- misalign_err:
  - Registered: <= pc_src & (pc_target[1:0] != 2'b00).
  - High for exactly the cycle after the redirect edge; otherwise 0.
  - PC is still redirected to the word-aligned address.
- fetch_count increments by 1 on every edge where IF/ID loads under rule 3. It wraps from all-ones to 0 and never saturates.
- stall_f=1 with stall_d=0 is legal:
  - IF/ID reloads the same pc and instruction.
  - fetch_count increments.
  - The hazard unit is responsible for not using this combination.
- Reset deasserted mid-stall or mid-redirect: first post-reset edge fetches RESET_PC regardless of the stall/redirect inputs present during reset.
- No X propagation: all outputs are defined from the first post-reset cycle.

Test Plan:
- Reset then free-run, imem holding word i = 0x1000_0000+i, RESET_PC=0 -> after edges 1..3: if_id_pc = 0,4,8; if_id_ins = 0x1000_0000, 0x1000_0001, 0x1000_0002; valid=1; fetch_count=3.
- Load-use: stall_f=stall_d=1 for 2 cycles with pc=0x10 -> imem_addr stays 0x10, IF/ID holds pc 0x0C, fetch_count frozen. After release: pc=0x14, if_id_pc=0x10.
- Taken branch: pc=0x20, pc_src=1, pc_target=0x100, flush_d=1 -> next cycle pc=0x100, if_id_ins=0x0000_0013, valid=0. Following cycle if_id_pc=0x100, valid=1.
- Flush+stall conflict: flush_d=1 and stall_d=1 together -> IF/ID becomes bubble (valid=0, ins=NOP_INS).
- Misaligned jalr: pc_src=1, pc_target=0x0000_0206 -> pc=0x204, misalign_err=1 for one cycle then 0.
- Edge cases:
  - pc=0xFFFF_FFFC free-running -> pc wraps to 0x0000_0000.
  - fetch_count preloaded near max (CNT_W=4 build) -> wraps 15 to 0.
  - rst=1 while pc_src=1 -> pc=RESET_PC.
